crc_host_if_mc: RTL and testbench
=================================

// Module: crc_host_if_mc
// PURPOSE
//  AHB-Lite slave front end for NUM_CH independent CRC engines. Decodes a per-channel register
//  window, holds each channel's control register, stalls via HREADYOUT on per-channel back-pressure,
//  and returns a two-cycle AHB ERROR on illegal accesses. Successor to the single-channel host IF.
// PARAMETERS
//  NUM_CH      2  number of CRC channels (1..8); CH_W = max(1,$clog2(NUM_CH))
//  CH_SHIFT    5  log2 of per-channel window in bytes; channel = HADDR[CH_SHIFT +: CH_W]
//  ERR_EN      1  1: illegal accesses get ERROR response; 0: completed as OKAY, write ignored, reads 0
// PORTS
//  HCLK             in   1         clock
//  HRESET           in   1         synchronous reset, active-high
//  HSElx/HWRITE     in   1         AHB select / write
//  HADDR            in   32        AHB address
//  HTRANS           in   2         AHB transfer type
//  HSIZE            in   3         AHB transfer size
//  HWDATA           in   32        write data (data phase)
//  HREADY           in   1         bus ready (muxed)
//  HRDATA           out  32        read data
//  HREADYOUT        out  1         slave ready
//  HRESP            out  1         0 OKAY, 1 ERROR
//  bus_wr           out  32        HWDATA passthrough to all channels
//  bus_size         out  2         HSIZE[1:0] of current data phase
//  buffer_write_en  out  NUM_CH    DR write strobe, one cycle per transfer
//  dr_read_en       out  NUM_CH    DR read strobe, one cycle per transfer
//  crc_init_en/crc_idr_en/crc_poly_en out NUM_CH  INIT/IDR/POL write strobes
//  reset_chain      out  NUM_CH    one-cycle pulse on CR write with HWDATA[0]=1
//  crc_poly_size/rev_in_type out 2*NUM_CH; rev_out_type out NUM_CH  per-channel CR fields
//  crc_out/crc_init_out/crc_poly_out in 32*NUM_CH; crc_idr_out in 8*NUM_CH  readback
//  buffer_full/read_wait/reset_pending in NUM_CH  per-channel stall sources
// BEHAVIOUR
//  Map per channel (offset HADDR[4:2]): 0 DR, 1 IDR, 2 CR, 3 STATUS(RO), 4 INIT, 5 POL, 6-7 unmapped.
//  STATUS read = {29'h0, reset_pending, read_wait, buffer_full} of that channel.
//  CR read = {24'h0, rev_out, rev_in[1:0], poly_size[1:0], 3'h0}; write loads HWDATA[7],[6:5],[4:3].
//  Address phase sampled when HREADY=1 and HSElx=1 and HTRANS is NONSEQ or SEQ; IDLE/BUSY -> no transfer.
//  Illegal: channel >= NUM_CH, offset 6/7, write to STATUS, HSIZE > 2.
//  FSM: IDLE, DATA, ERR1, ERR2.
//   IDLE/DATA(completing)/ERR2 + valid sample -> DATA; + illegal (ERR_EN=1) -> ERR1; else -> IDLE.
//   DATA: stall while (DR wr & buffer_full[ch]) | (DR rd & read_wait[ch]) | (INIT wr & reset_pending[ch]).
//   ERR1 -> ERR2 unconditionally.
//  Outputs: DATA stalled: HREADYOUT=0,HRESP=0; DATA completing: HREADYOUT=1; ERR1: HREADYOUT=0,HRESP=1;
//   ERR2: HREADYOUT=1,HRESP=1; IDLE: HREADYOUT=1,HRESP=0.
//  All strobes fire only in the completing DATA cycle, exactly one cycle per transfer, only for the
//   addressed channel; never during stall or error. CR and reset_chain update in same cycle.
//  HRDATA valid in completing DATA cycle of a read; 0 in all other states.
//  Zero-wait back-to-back transfers sustain one transfer per cycle, incl. alternating channels.
//  Reset (any state, incl. mid-stall/mid-error): FSM->IDLE, pending transfer dropped, all CRs 0,
//   all strobes 0, HREADYOUT=1, HRESP=0, HRDATA=0 in the cycle after HRESET sampled high.
// TESTING
//  1 Reset, then read 0x08 and 0x28 -> HRDATA 0, HREADYOUT=1, HRESP=0, zero wait states.
//  2 Write 0x28 HWDATA=0xE9 -> ch1 rev_out=1, rev_in=3, poly_size=1, reset_chain=2'b10 one cycle;
//    ch0 unchanged; read 0x28 -> 0xE8.
//  3 buffer_full[0]=1 for 3 cycles, write 0x00 -> HREADYOUT low 3 cycles, buffer_write_en[0] single
//    pulse on release cycle.
//  4 Read 0x18 (unmapped), and with NUM_CH=2 read 0x40 -> each: ERR1 (HREADYOUT=0,HRESP=1) then
//    ERR2 (HREADYOUT=1,HRESP=1), no strobes; ERR_EN=0 -> OKAY, HRDATA=0.
//  5 NONSEQ+SEQ writes 0x00,0x20,0x00 zero-wait -> buffer_write_en 01,10,01 on consecutive cycles.
//  6 HRESET asserted during 3's stall -> next cycle HREADYOUT=1, no write strobe ever issued, CRs 0.

Source files
------------

// File: rtl/crc_host_if_mc_if.sv
// AHB-Lite signal bundle between a bus master and the multi-channel CRC host front end.
interface crc_host_if_mc_if;
  logic        HSElx;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSElx, HWRITE, HADDR, HTRANS, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSElx, HWRITE, HADDR, HTRANS, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/crc_host_if_mc.sv
// AHB-Lite slave front end for NUM_CH CRC engines: per-channel register decode, control
// registers, back-pressure stalls and two-cycle ERROR responses.
module crc_host_if_mc #(
  parameter int  NUM_CH   = 2,
  parameter int  CH_SHIFT = 5,
  parameter int  ERR_EN   = 1,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  crc_host_if_mc_if.slave       ahb,
  output logic [31:0]           bus_wr,
  output logic [1:0]            bus_size,
  output logic [NUM_CH-1:0]     buffer_write_en,
  output logic [NUM_CH-1:0]     dr_read_en,
  output logic [NUM_CH-1:0]     crc_init_en,
  output logic [NUM_CH-1:0]     crc_idr_en,
  output logic [NUM_CH-1:0]     crc_poly_en,
  output logic [NUM_CH-1:0]     reset_chain,
  output logic [2*NUM_CH-1:0]   crc_poly_size,
  output logic [2*NUM_CH-1:0]   rev_in_type,
  output logic [NUM_CH-1:0]     rev_out_type,
  input  logic [32*NUM_CH-1:0]  crc_out,
  input  logic [32*NUM_CH-1:0]  crc_init_out,
  input  logic [32*NUM_CH-1:0]  crc_poly_out,
  input  logic [8*NUM_CH-1:0]   crc_idr_out,
  input  logic [NUM_CH-1:0]     buffer_full,
  input  logic [NUM_CH-1:0]     read_wait,
  input  logic [NUM_CH-1:0]     reset_pending
);

  // IDLE: no transfer | DATA: data phase (may stall) | ERR1/ERR2: two-cycle ERROR response
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

  localparam logic [2:0] OFF_DR   = 3'd0;
  localparam logic [2:0] OFF_IDR  = 3'd1;
  localparam logic [2:0] OFF_CR   = 3'd2;
  localparam logic [2:0] OFF_STAT = 3'd3;
  localparam logic [2:0] OFF_INIT = 3'd4;
  localparam logic [2:0] OFF_POL  = 3'd5;

  state_t            state, state_nxt;
  logic [31:0]       a_chn;
  logic [2:0]        a_off;
  logic              a_valid, a_bad, take, stall, done, wr_done, rd_done;
  logic              hready_o, hresp_o;
  logic [CH_W-1:0]   d_ch;
  logic [2:0]        d_off;
  logic              d_wr, d_bad;
  logic [1:0]        d_size;
  logic [NUM_CH-1:0] ch_sel;
  logic [31:0]       rdata;
  logic              addr_lsb_unused;

  // The full upper address is compared so addresses beyond the last window are rejected.
  assign a_chn           = ahb.HADDR >> CH_SHIFT;
  assign a_off           = ahb.HADDR[4:2];
  assign addr_lsb_unused = ^ahb.HADDR[1:0];
  assign a_valid         = ahb.HSElx & ahb.HREADY & ahb.HTRANS[1];
  assign a_bad           = (a_chn >= 32'(NUM_CH)) | (a_off > OFF_POL) |
                           (ahb.HWRITE & (a_off == OFF_STAT)) | (ahb.HSIZE > 3'd2);
  assign take            = a_valid & hready_o;

  assign stall = (state == S_DATA) & ~d_bad & (
                   ((d_off == OFF_DR)   &  d_wr & buffer_full[d_ch]) |
                   ((d_off == OFF_DR)   & ~d_wr & read_wait[d_ch])   |
                   ((d_off == OFF_INIT) &  d_wr & reset_pending[d_ch]));

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (hready_o) begin
          if (!take)                      state_nxt = S_IDLE;
          else if (a_bad && (ERR_EN != 0)) state_nxt = S_ERR1;
          else                            state_nxt = S_DATA;
        end
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    hready_o = 1'b1;
    hresp_o  = 1'b0;
    done     = 1'b0;
    case (state)
      S_DATA: begin
        hready_o = ~stall;
        done     = ~stall & ~d_bad;
      end
      S_ERR1: begin
        hready_o = 1'b0;
        hresp_o  = 1'b1;
      end
      S_ERR2:  hresp_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      d_ch   <= '0;
      d_off  <= '0;
      d_wr   <= 1'b0;
      d_bad  <= 1'b0;
      d_size <= '0;
    end else if (take) begin
      d_ch   <= a_chn[CH_W-1:0];
      d_off  <= a_off;
      d_wr   <= ahb.HWRITE;
      d_bad  <= a_bad;
      d_size <= ahb.HSIZE[1:0];
    end
  end

  assign wr_done = done & d_wr;
  assign rd_done = done & ~d_wr;
  assign ch_sel  = NUM_CH'(1) << d_ch;

  assign buffer_write_en = (wr_done && d_off == OFF_DR)   ? ch_sel : '0;
  assign dr_read_en      = (rd_done && d_off == OFF_DR)   ? ch_sel : '0;
  assign crc_idr_en      = (wr_done && d_off == OFF_IDR)  ? ch_sel : '0;
  assign crc_init_en     = (wr_done && d_off == OFF_INIT) ? ch_sel : '0;
  assign crc_poly_en     = (wr_done && d_off == OFF_POL)  ? ch_sel : '0;
  assign reset_chain     = (wr_done && d_off == OFF_CR && ahb.HWDATA[0]) ? ch_sel : '0;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rev_out_type  <= '0;
      rev_in_type   <= '0;
      crc_poly_size <= '0;
    end else if (wr_done && d_off == OFF_CR) begin
      rev_out_type[d_ch]          <= ahb.HWDATA[7];
      rev_in_type[2*d_ch +: 2]    <= ahb.HWDATA[6:5];
      crc_poly_size[2*d_ch +: 2]  <= ahb.HWDATA[4:3];
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_done) begin
      case (d_off)
        OFF_DR:   rdata = crc_out[32*d_ch +: 32];
        OFF_IDR:  rdata = {24'h0, crc_idr_out[8*d_ch +: 8]};
        OFF_CR:   rdata = {24'h0, rev_out_type[d_ch], rev_in_type[2*d_ch +: 2],
                           crc_poly_size[2*d_ch +: 2], 3'h0};
        OFF_STAT: rdata = {29'h0, reset_pending[d_ch], read_wait[d_ch], buffer_full[d_ch]};
        OFF_INIT: rdata = crc_init_out[32*d_ch +: 32];
        OFF_POL:  rdata = crc_poly_out[32*d_ch +: 32];
        default:  rdata = '0;
      endcase
    end
  end

  assign ahb.HRDATA    = rdata;
  assign ahb.HREADYOUT = hready_o;
  assign ahb.HRESP     = hresp_o;
  assign bus_wr        = ahb.HWDATA;
  assign bus_size      = d_size;

endmodule

// File: tb/tb_crc_host_if_mc.sv
// Scoreboard bench for crc_host_if_mc: the driver queues expected responses, a negedge monitor
// checks every completed data phase plus idle-cycle outputs; a second instance runs with ERR_EN=0.
module tb_crc_host_if_mc;
  localparam int NUM_CH = 2;
  localparam int K_RC = 0, K_POL = 1, K_IDR = 2, K_INIT = 3, K_DRRD = 4, K_DRWR = 5;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  crc_host_if_mc_if bus();
  crc_host_if_mc_if bus_ne();
  assign bus.HREADY    = bus.HREADYOUT;
  assign bus_ne.HREADY = bus_ne.HREADYOUT;

  logic [31:0]          bus_wr, bus_wr_ne;
  logic [1:0]           bus_size, bus_size_ne;
  logic [NUM_CH-1:0]    bwe, drd, ien, iden, pen, rch, rev_out;
  logic [NUM_CH-1:0]    bwe_ne, drd_ne, ien_ne, iden_ne, pen_ne, rch_ne, rev_out_ne;
  logic [2*NUM_CH-1:0]  poly_sz, rev_in, poly_sz_ne, rev_in_ne;
  logic [32*NUM_CH-1:0] crc_out, crc_init_out, crc_poly_out;
  logic [8*NUM_CH-1:0]  crc_idr_out;
  logic [NUM_CH-1:0]    buffer_full, read_wait, reset_pending;
  logic [NUM_CH-1:0]    zero_ch;
  logic [11:0]          strb, strb_ne;

  assign zero_ch = '0;
  assign strb    = {bwe, drd, ien, iden, pen, rch};
  assign strb_ne = {bwe_ne, drd_ne, ien_ne, iden_ne, pen_ne, rch_ne};

  crc_host_if_mc #(.NUM_CH(NUM_CH), .CH_SHIFT(5), .ERR_EN(1)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .ahb(bus),
    .bus_wr(bus_wr), .bus_size(bus_size),
    .buffer_write_en(bwe), .dr_read_en(drd), .crc_init_en(ien), .crc_idr_en(iden),
    .crc_poly_en(pen), .reset_chain(rch),
    .crc_poly_size(poly_sz), .rev_in_type(rev_in), .rev_out_type(rev_out),
    .crc_out(crc_out), .crc_init_out(crc_init_out), .crc_poly_out(crc_poly_out),
    .crc_idr_out(crc_idr_out),
    .buffer_full(buffer_full), .read_wait(read_wait), .reset_pending(reset_pending)
  );

  crc_host_if_mc #(.NUM_CH(NUM_CH), .CH_SHIFT(5), .ERR_EN(0)) dut_ne (
    .HCLK(HCLK), .HRESET(HRESET), .ahb(bus_ne),
    .bus_wr(bus_wr_ne), .bus_size(bus_size_ne),
    .buffer_write_en(bwe_ne), .dr_read_en(drd_ne), .crc_init_en(ien_ne), .crc_idr_en(iden_ne),
    .crc_poly_en(pen_ne), .reset_chain(rch_ne),
    .crc_poly_size(poly_sz_ne), .rev_in_type(rev_in_ne), .rev_out_type(rev_out_ne),
    .crc_out(crc_out), .crc_init_out(crc_init_out), .crc_poly_out(crc_poly_out),
    .crc_idr_out(crc_idr_out),
    .buffer_full(zero_ch), .read_wait(zero_ch), .reset_pending(zero_ch)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        resp;
    int          waits;
    logic [11:0] strb;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic logic [11:0] sv(input int kind, input int ch);
    logic [11:0] one;
    one = 12'd1;
    return one << (kind*2 + ch);
  endfunction

  task automatic issue(input string nm, input logic [31:0] addr, input logic wr,
                       input logic [31:0] wdata, input logic [2:0] size, input logic seq,
                       input logic [31:0] rdata, input logic resp, input int waits,
                       input logic [11:0] s, input bit push = 1'b1);
    exp_t e;
    int n;
    if (push) begin
      e.name = nm; e.rdata = rdata; e.resp = resp; e.waits = waits; e.strb = s;
      q.push_back(e);
    end
    bus.HSElx  = 1'b1;
    bus.HADDR  = addr;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
    bus.HTRANS = seq ? 2'b11 : 2'b10;
    n = 0;
    @(negedge HCLK);
    while (!bus.HREADY && n < 50) begin
      @(negedge HCLK);
      n++;
    end
    if (!bus.HREADY) begin
      total++; bad++;
      $display("FAIL %s accept timeout: hready %b want 1", nm, bus.HREADY);
    end
    @(posedge HCLK); #1;
    bus.HWDATA = wdata;
  endtask

  task automatic bus_idle();
    bus.HSElx  = 1'b0;
    bus.HTRANS = 2'b00;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge HCLK);
    while (!bus.HREADY && n < 50) begin
      @(negedge HCLK);
      n++;
    end
    if (!bus.HREADY) begin
      total++; bad++;
      $display("FAIL drain timeout: hready %b want 1", bus.HREADY);
    end
    @(posedge HCLK); #1;
  endtask

  // single transfer on the ERR_EN=0 instance; every one must complete OKAY, zero-wait, silent
  task automatic ne_xfer(input string nm, input logic [31:0] addr, input logic wr,
                         input logic [2:0] size);
    bus_ne.HSElx  = 1'b1;
    bus_ne.HADDR  = addr;
    bus_ne.HWRITE = wr;
    bus_ne.HSIZE  = size;
    bus_ne.HTRANS = 2'b10;
    @(posedge HCLK); #1;
    bus_ne.HSElx  = 1'b0;
    bus_ne.HTRANS = 2'b00;
    bus_ne.HWDATA = 32'hFFFF_FFFF;
    @(negedge HCLK);
    chk({nm, " hreadyout"}, 32'(bus_ne.HREADYOUT), 32'd1);
    chk({nm, " hresp"},     32'(bus_ne.HRESP),     32'd0);
    chk({nm, " hrdata"},    bus_ne.HRDATA,         32'd0);
    chk({nm, " strobes"},   32'(strb_ne),          32'd0);
    @(posedge HCLK); #1;
  endtask

  initial begin : monitor
    bit dp;
    int waits;
    exp_t e;
    dp = 1'b0;
    waits = 0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        dp = 1'b0;
        waits = 0;
      end else begin
        if (dp && bus.HREADYOUT) begin
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected completion: queue size %0d want >0", q.size());
          end else begin
            e = q.pop_front();
            chk({e.name, " rdata"}, bus.HRDATA, e.rdata);
            chk({e.name, " resp"},  32'(bus.HRESP), 32'(e.resp));
            chk({e.name, " waits"}, 32'(waits), 32'(e.waits));
            chk({e.name, " strb"},  32'(strb), 32'(e.strb));
          end
          waits = 0;
        end else if (dp) begin
          waits++;
          chk("stall strb", 32'(strb), 32'd0);
        end else begin
          chk("idle outputs", {bus.HRDATA[28:0], bus.HREADYOUT, bus.HRESP, |strb},
              {29'd0, 1'b1, 1'b0, 1'b0});
        end
        if (bus.HREADYOUT) dp = bus.HSElx & bus.HTRANS[1] & bus.HREADY;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t want finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET        = 1'b1;
    bus.HSElx     = 1'b0; bus.HWRITE = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00;
    bus.HSIZE     = 3'd2; bus.HWDATA = '0;
    bus_ne.HSElx  = 1'b0; bus_ne.HWRITE = 1'b0; bus_ne.HADDR = '0; bus_ne.HTRANS = 2'b00;
    bus_ne.HSIZE  = 3'd2; bus_ne.HWDATA = '0;
    crc_out       = {32'hB1B1_0001, 32'hA0A0_0000};
    crc_init_out  = {32'h1111_2222, 32'h3333_4444};
    crc_poly_out  = {32'h04C1_1DB7, 32'h1EDC_6F41};
    crc_idr_out   = 16'h5A3C;
    buffer_full   = '0;
    read_wait     = '0;
    reset_pending = '0;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    chk("reset hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("reset hresp",     32'(bus.HRESP),     32'd0);
    chk("reset cr fields", {26'd0, rev_out, rev_in, poly_sz[1:0]}, 32'd0);
    @(posedge HCLK); #1;

    // reset-value reads, zero wait
    issue("rd_cr0", 32'h08, 1'b0, 0, 3'd2, 1'b0, 32'h0, 1'b0, 0, 12'h0);
    issue("rd_cr1", 32'h28, 1'b0, 0, 3'd2, 1'b1, 32'h0, 1'b0, 0, 12'h0);
    bus_idle(); drain();

    // CR write on ch1 with reset_chain, then ch0 without
    issue("wr_cr1", 32'h28, 1'b1, 32'hE9, 3'd2, 1'b0, 32'h0, 1'b0, 0, sv(K_RC, 1));
    bus_idle(); drain();
    chk("cr1 rev_out",   32'(rev_out), 32'h2);
    chk("cr1 rev_in",    32'(rev_in),  32'hC);
    chk("cr1 poly_size", 32'(poly_sz), 32'h4);
    issue("rd_cr1b", 32'h28, 1'b0, 0, 3'd2, 1'b0, 32'hE8, 1'b0, 0, 12'h0);
    issue("rd_cr0b", 32'h08, 1'b0, 0, 3'd2, 1'b1, 32'h00, 1'b0, 0, 12'h0);
    issue("wr_cr0",  32'h08, 1'b1, 32'h30, 3'd2, 1'b1, 32'h0, 1'b0, 0, 12'h0);
    issue("rd_cr0c", 32'h08, 1'b0, 0, 3'd2, 1'b1, 32'h30, 1'b0, 0, 12'h0);
    bus_idle(); drain();
    chk("cr0 rev_in",    32'(rev_in),  32'hD);
    chk("cr0 poly_size", 32'(poly_sz), 32'h6);

    // readback and write strobes across both channels
    read_wait     = 2'b10;
    reset_pending = 2'b01;
    issue("rd_dr0",   32'h00, 1'b0, 0, 3'd2, 1'b0, 32'hA0A0_0000, 1'b0, 0, sv(K_DRRD, 0));
    issue("rd_idr1",  32'h24, 1'b0, 0, 3'd0, 1'b1, 32'h5A,        1'b0, 0, 12'h0);
    issue("rd_init1", 32'h30, 1'b0, 0, 3'd2, 1'b1, 32'h1111_2222, 1'b0, 0, 12'h0);
    issue("rd_pol0",  32'h14, 1'b0, 0, 3'd2, 1'b1, 32'h1EDC_6F41, 1'b0, 0, 12'h0);
    issue("rd_st0",   32'h0C, 1'b0, 0, 3'd2, 1'b1, 32'h4,         1'b0, 0, 12'h0);
    issue("rd_st1",   32'h2C, 1'b0, 0, 3'd2, 1'b1, 32'h2,         1'b0, 0, 12'h0);
    issue("wr_idr0",  32'h04, 1'b1, 32'h77, 3'd0, 1'b1, 32'h0, 1'b0, 0, sv(K_IDR, 0));
    issue("wr_pol1",  32'h34, 1'b1, 32'h99, 3'd2, 1'b1, 32'h0, 1'b0, 0, sv(K_POL, 1));
    bus_idle(); drain();
    read_wait     = '0;
    reset_pending = '0;

    // back-pressure stalls
    buffer_full = 2'b01;
    issue("wr_dr0_stall", 32'h00, 1'b1, 32'h1234, 3'd2, 1'b0, 32'h0, 1'b0, 3, sv(K_DRWR, 0));
    bus_idle();
    repeat (3) @(posedge HCLK);
    #1 buffer_full = '0;
    drain();
    read_wait = 2'b10;
    issue("rd_dr1_stall", 32'h20, 1'b0, 0, 3'd2, 1'b0, 32'hB1B1_0001, 1'b0, 2, sv(K_DRRD, 1));
    bus_idle();
    repeat (2) @(posedge HCLK);
    #1 read_wait = '0;
    drain();
    reset_pending = 2'b01;
    issue("wr_init0_stall", 32'h10, 1'b1, 32'h5, 3'd2, 1'b0, 32'h0, 1'b0, 1, sv(K_INIT, 0));
    bus_idle();
    @(posedge HCLK);
    #1 reset_pending = '0;
    drain();
    buffer_full = 2'b01;
    issue("wr_dr1_other_full", 32'h20, 1'b1, 32'h9, 3'd2, 1'b0, 32'h0, 1'b0, 0, sv(K_DRWR, 1));
    bus_idle(); drain();
    buffer_full = '0;

    // illegal accesses -> two-cycle ERROR
    issue("err_unmapped", 32'h18, 1'b0, 0, 3'd2, 1'b0, 32'h0, 1'b1, 1, 12'h0);
    bus_idle(); drain();
    issue("err_ch2",      32'h40, 1'b0, 0, 3'd2, 1'b0, 32'h0, 1'b1, 1, 12'h0);
    bus_idle(); drain();
    issue("err_wr_stat",  32'h0C, 1'b1, 32'hFF, 3'd2, 1'b0, 32'h0, 1'b1, 1, 12'h0);
    bus_idle(); drain();
    issue("err_size",     32'h00, 1'b1, 32'hFF, 3'd3, 1'b0, 32'h0, 1'b1, 1, 12'h0);
    bus_idle(); drain();

    // ERR_EN=0: illegal accesses complete OKAY, read 0, writes dropped
    ne_xfer("ne_rd_unmapped", 32'h18, 1'b0, 3'd2);
    ne_xfer("ne_rd_ch2",      32'h40, 1'b0, 3'd2);
    ne_xfer("ne_wr_cr_ch2",   32'h48, 1'b1, 3'd2);
    ne_xfer("ne_wr_cr_size",  32'h08, 1'b1, 3'd3);
    chk("ne cr fields", {26'd0, rev_out_ne, rev_in_ne, poly_sz_ne[1:0]}, 32'd0);

    // zero-wait back-to-back DR writes alternating channels
    issue("b2b_0", 32'h00, 1'b1, 32'h1, 3'd2, 1'b0, 32'h0, 1'b0, 0, sv(K_DRWR, 0));
    issue("b2b_1", 32'h20, 1'b1, 32'h2, 3'd2, 1'b1, 32'h0, 1'b0, 0, sv(K_DRWR, 1));
    issue("b2b_2", 32'h00, 1'b1, 32'h3, 3'd2, 1'b1, 32'h0, 1'b0, 0, sv(K_DRWR, 0));
    bus_idle(); drain();

    // reset during a stalled DR write: transfer dropped, CRs cleared
    buffer_full = 2'b01;
    issue("wr_rst", 32'h00, 1'b1, 32'hDEAD, 3'd2, 1'b0, 32'h0, 1'b0, 0, 12'h0, 1'b0);
    bus_idle();
    @(posedge HCLK);
    #1 HRESET = 1'b1;
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    chk("post-reset hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("post-reset hresp",     32'(bus.HRESP),     32'd0);
    chk("post-reset cr fields", {26'd0, rev_out, rev_in, poly_sz[1:0]}, 32'd0);
    chk("post-reset poly1",     32'(poly_sz[3:2]), 32'd0);
    repeat (3) @(posedge HCLK);
    #1 buffer_full = '0;
    repeat (2) @(posedge HCLK);
    #1;
    issue("rd_cr1_after_rst", 32'h28, 1'b0, 0, 3'd2, 1'b0, 32'h0, 1'b0, 0, 12'h0);
    bus_idle(); drain();

    repeat (3) @(posedge HCLK);
    chk("queue empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
